banked_mem: RTL

BANKED_MEM -- requirements
Module: banked_mem

---
 rtl/banked_mem_pkg.sv | 8 +
 rtl/mem_lane.sv | 33 +++
 rtl/banked_mem.sv | 108 ++++++++++
 3 files changed

// File: rtl/banked_mem_pkg.sv
// banked_mem shared types: FSM state encoding and default geometry.
package banked_mem_pkg;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
endpackage

// File: rtl/mem_lane.sv
// One LANE_W x DEPTH byte-lane bank: synchronous write, registered read.
// Latency: read data valid 1 cycle after re. No backpressure; out-of-range reads return zero.
// Stored entries carry no reset; only the read register clears.
module mem_lane #(
  parameter int LANE_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LANE_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LANE_W-1:0] rdata
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= ({1'b0, raddr} < DEPTH_L) ? mem[raddr] : '0;
    end
  end
endmodule

// File: rtl/banked_mem.sv
// Byte-lane banked memory; self-clears on reset, then accepts one request per cycle.
// Latency: read 1 cycle (2 with BANKED_MEM_RSP_REG_EN). Backpressure: req_ready low only during the clear.
// Writes are posted; reads always produce exactly one rsp_valid pulse.
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int   LANES  = LANES_DEF,
  parameter int   LANE_W = LANE_W_DEF,
  parameter int   DEPTH  = DEPTH_DEF,
  localparam int  ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [LANES-1:0]        req_be,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES*LANE_W-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [LANES*LANE_W-1:0] rsp_rdata,
  output logic                    init_done
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q;
  logic                    init_we;
  logic                    addr_ok, wr_acc, rd_acc;
  logic                    rd_vld_q;
  logic [LANES*LANE_W-1:0] lane_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (init_we) cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    init_we   = 1'b0;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  assign addr_ok = {1'b0, req_addr} < DEPTH_L;
  assign wr_acc  = req_valid && req_ready && req_we && addr_ok;
  assign rd_acc  = req_valid && req_ready && !req_we;

  // The clear owns the write port while INIT; requests cannot be accepted then anyway.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mem_lane #(
      .LANE_W(LANE_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (init_we | (wr_acc & req_be[i])),
      .waddr(init_we ? cnt_q : req_addr),
      .wdata(init_we ? '0 : req_wdata[i*LANE_W +: LANE_W]),
      .re   (rd_acc),
      .raddr(req_addr),
      .rdata(lane_rdata[i*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_q <= 1'b0;
    else        rd_vld_q <= rd_acc;
  end

`ifdef BANKED_MEM_RSP_REG_EN
  logic                    rsp_vld_q;
  logic [LANES*LANE_W-1:0] rsp_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      rsp_vld_q <= rd_vld_q;
      if (rd_vld_q) rsp_dat_q <= lane_rdata;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_rdata = rsp_dat_q;
`else
  assign rsp_valid = rd_vld_q;
  assign rsp_rdata = lane_rdata;
`endif
endmodule
